// File: rtl/score_keeper.sv
// score_keeper: judges arrow hits, tracks combo, applies a combo multiplier
// and accumulates a saturating 16-bit score that is shown once per frame.
// Ports: Clk, reset (sync, active-high), frame_clk, song_start, song_end,
//   hit_valid, hit_dist[9:0], miss_valid -> score[15:0], combo[9:0],
//   judgement[2:0], judge_valid, playing.
// Option: define SCORE_ROLLUP_EN to make the shown score count up by at
//   most 64 per frame edge instead of jumping straight to the raw score.
module score_keeper #(
   parameter int PERFECT_WIN = 4,
   parameter int GREAT_WIN   = 10,
   parameter int GOOD_WIN    = 20,
   parameter int MULT_STEP   = 16,
   parameter int MULT_MAX    = 4
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        frame_clk,
   input  logic        song_start,
   input  logic        song_end,
   input  logic        hit_valid,
   input  logic [9:0]  hit_dist,
   input  logic        miss_valid,
   output logic [15:0] score,
   output logic [9:0]  combo,
   output logic [2:0]  judgement,
   output logic        judge_valid,
   output logic        playing
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PLAY   = 2'd1;
   localparam logic [1:0] S_RESULT = 2'd2;

   localparam logic [2:0] J_MISS = 3'd5;

   logic [1:0]  state;
   logic [15:0] raw;
   logic [1:0]  pend;
   logic        frame_q;
   logic        s2_valid;
   logic [12:0] s2_add;

   logic        in_play;
   logic        active;
   logic        start;
   logic        do_hit;
   logic        do_miss;
   logic        do_drain;
   logic        frame_rise;
   logic [8:0]  base;
   logic [2:0]  jcode;
   logic [9:0]  step_cnt;
   logic [3:0]  mult;
   logic [12:0] add_nxt;
   logic [16:0] sum;

   assign playing    = (state == S_PLAY);
   assign in_play    = (state == S_PLAY);
   // song_end wins over any event arriving in the same cycle
   assign active     = in_play & ~song_end;
   assign start      = song_start & ~in_play;
   assign do_hit     = active & hit_valid;
   assign do_miss    = active & miss_valid & ~hit_valid;
   // queued misses only drain in otherwise quiet cycles
   assign do_drain   = active & ~hit_valid & ~miss_valid
                     & (pend != 2'd0);
   assign frame_rise = frame_clk & ~frame_q;

   always_comb begin
      base  = 9'd0;
      jcode = 3'd4;
      if (hit_dist <= 10'(PERFECT_WIN)) begin
         base  = 9'd300;
         jcode = 3'd1;
      end else if (hit_dist <= 10'(GREAT_WIN)) begin
         base  = 9'd200;
         jcode = 3'd2;
      end else if (hit_dist <= 10'(GOOD_WIN)) begin
         base  = 9'd100;
         jcode = 3'd3;
      end
   end

   // multiplier uses the combo as it stood before this hit
   always_comb begin
      step_cnt = 10'(combo / 10'(MULT_STEP));
      if (step_cnt >= 10'(MULT_MAX - 1))
         mult = 4'(MULT_MAX);
      else
         mult = 4'(step_cnt) + 4'd1;
   end

   assign add_nxt = 13'(base) * 13'(mult);
   assign sum     = {1'b0, raw} + 17'(s2_add);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state       <= S_IDLE;
         raw         <= '0;
         pend        <= '0;
         frame_q     <= 1'b0;
         s2_valid    <= 1'b0;
         s2_add      <= '0;
         score       <= '0;
         combo       <= '0;
         judgement   <= '0;
         judge_valid <= 1'b0;
      end else begin
         frame_q     <= frame_clk;
         judge_valid <= 1'b0;

`ifdef SCORE_ROLLUP_EN
         if (frame_rise && score < raw) begin
            if (raw - score > 16'd64)
               score <= score + 16'd64;
            else
               score <= raw;
         end
`else
         if (frame_rise)
            score <= raw;
`endif

         if (s2_valid)
            raw <= sum[16] ? 16'hFFFF : sum[15:0];
         s2_valid <= do_hit;
         s2_add   <= add_nxt;

         if (do_hit) begin
            judgement   <= jcode;
            judge_valid <= 1'b1;
            if (base == 9'd0)
               combo <= '0;
            else if (combo != 10'h3FF)
               combo <= combo + 10'd1;
         end else if (do_miss || do_drain) begin
            judgement   <= J_MISS;
            judge_valid <= 1'b1;
            combo       <= '0;
         end

         if (do_hit && miss_valid && pend != 2'd3)
            pend <= pend + 2'd1;
         else if (do_drain)
            pend <= pend - 2'd1;

         unique case (state)
            S_IDLE, S_RESULT: if (song_start) state <= S_PLAY;
            S_PLAY:           if (song_end) state <= S_RESULT;
            default:          state <= S_IDLE;
         endcase

         if (start) begin
            raw      <= '0;
            combo    <= '0;
            pend     <= '0;
            s2_valid <= 1'b0;
`ifdef SCORE_ROLLUP_EN
            score    <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a cycle-level reference model
// driven by the same inputs, literal spot checks and a random phase.
module tb_score_keeper;

   logic        Clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_clk = 1'b0;
   logic        song_start = 1'b0;
   logic        song_end = 1'b0;
   logic        hit_valid = 1'b0;
   logic [9:0]  hit_dist = '0;
   logic        miss_valid = 1'b0;
   logic [15:0] score;
   logic [9:0]  combo;
   logic [2:0]  judgement;
   logic        judge_valid;
   logic        playing;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 Clk = ~Clk;

   score_keeper dut (
      .Clk(Clk), .reset(reset), .frame_clk(frame_clk),
      .song_start(song_start), .song_end(song_end),
      .hit_valid(hit_valid), .hit_dist(hit_dist),
      .miss_valid(miss_valid), .score(score), .combo(combo),
      .judgement(judgement), .judge_valid(judge_valid),
      .playing(playing)
   );

   // reference model state (0 idle, 1 play, 2 result)
   int m_st = 0, m_combo = 0, m_pend = 0, m_judge = 0;
   int m_raw = 0, m_due = -1, m_score = 0;
   bit m_jv = 1'b0, m_fq = 1'b0;

   always @(posedge Clk) begin : model
      int st, cb, pd, jd, rw, du, sc, base, mult;
      bit jv, fq, act, rise;
      st = m_st; cb = m_combo; pd = m_pend; jd = m_judge;
      rw = m_raw; du = m_due; sc = m_score; jv = m_jv; fq = m_fq;
      base = 0; mult = 1; act = 0; rise = 0;
      if (reset) begin
         st = 0; cb = 0; pd = 0; jd = 0; jv = 0;
         rw = 0; du = -1; sc = 0; fq = 0;
      end else begin
         jv = 0;
         rise = frame_clk && !fq;
         fq = frame_clk;
`ifdef SCORE_ROLLUP_EN
         if (rise && sc < rw) sc = (rw - sc > 64) ? sc + 64 : rw;
`else
         if (rise) sc = rw;
`endif
         if (du >= 0) begin
            rw = rw + du;
            if (rw > 65535) rw = 65535;
            du = -1;
         end
         act = (st == 1) && !song_end;
         if (act && hit_valid) begin
            if (hit_dist <= 4) begin base = 300; jd = 1; end
            else if (hit_dist <= 10) begin base = 200; jd = 2; end
            else if (hit_dist <= 20) begin base = 100; jd = 3; end
            else begin base = 0; jd = 4; end
            mult = 1 + cb / 16;
            if (mult > 4) mult = 4;
            du = base * mult;
            jv = 1;
            cb = (base == 0) ? 0 : ((cb < 1023) ? cb + 1 : 1023);
            if (miss_valid && pd < 3) pd = pd + 1;
         end else if (act && (miss_valid || pd > 0)) begin
            if (!miss_valid) pd = pd - 1;
            jd = 5; jv = 1; cb = 0;
         end
         if (st != 1 && song_start) begin
            st = 1; rw = 0; cb = 0; pd = 0; du = -1;
`ifdef SCORE_ROLLUP_EN
            sc = 0;
`endif
         end else if (st == 1 && song_end) begin
            st = 2;
         end
      end
      m_st <= st; m_combo <= cb; m_pend <= pd; m_judge <= jd;
      m_raw <= rw; m_due <= du; m_score <= sc; m_jv <= jv; m_fq <= fq;
   end

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         cmp("score", 32'(score), 32'(m_score));
         cmp("combo", 32'(combo), 32'(m_combo));
         cmp("judgement", 32'(judgement), 32'(m_judge));
         cmp("judge_valid", 32'(judge_valid), 32'(m_jv));
         cmp("playing", 32'(playing), 32'(m_st == 1));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic hit(input int d, input bit m);
      hit_valid = 1'b1; hit_dist = 10'(d); miss_valid = m;
      step();
      hit_valid = 1'b0; miss_valid = 1'b0;
   endtask

   task automatic restart();
      song_end = 1'b1; step(); song_end = 1'b0;
      song_start = 1'b1; step(); song_start = 1'b0;
   endtask

   task automatic frame();
      frame_clk = 1'b1; step();
      frame_clk = 1'b0; step();
   endtask

   task automatic settle();
`ifdef SCORE_ROLLUP_EN
      repeat (1030) frame();
`else
      frame();
`endif
   endtask

   int exp_s;

   initial begin
      // T1 reset
      reset = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b0;
      cmp("t1_score", 32'(score), 0);
      cmp("t1_combo", 32'(combo), 0);
      cmp("t1_judge", 32'(judgement), 0);
      cmp("t1_jv", 32'(judge_valid), 0);
      cmp("t1_playing", 32'(playing), 0);

      // T2 single perfect hit
      restart();
      cmp("t2_playing", 32'(playing), 1);
      hit(3, 0);
      cmp("t2_judge", 32'(judgement), 1);
      cmp("t2_jv", 32'(judge_valid), 1);
      cmp("t2_combo", 32'(combo), 1);
      step();
      cmp("t2_model_raw", 32'(m_raw), 300);
      settle();
      cmp("t2_score", 32'(score), 300);

      // T3 multiplier step at combo 16
      restart();
      repeat (16) hit(0, 0);
      step(); step();
      settle();
      cmp("t3_score16", 32'(score), 4800);
      hit(0, 0);
      step(); step();
      settle();
      cmp("t3_score17", 32'(score), 5400);
      cmp("t3_combo", 32'(combo), 17);

      // T4 hit with simultaneous miss
      restart();
      repeat (5) hit(0, 0);
      hit(8, 1);
      cmp("t4_judge", 32'(judgement), 2);
      cmp("t4_combo", 32'(combo), 6);
      step();
      cmp("t4_miss_judge", 32'(judgement), 5);
      cmp("t4_miss_combo", 32'(combo), 0);
      cmp("t4_miss_jv", 32'(judge_valid), 1);
      step();
      cmp("t4_quiet_jv", 32'(judge_valid), 0);
      settle();
      cmp("t4_score", 32'(score), 1700);

      // pending miss counter saturates at 3
      restart();
      repeat (5) hit(0, 1);
      step(); step(); step();
      cmp("pend_third_jv", 32'(judge_valid), 1);
      cmp("pend_third_judge", 32'(judgement), 5);
      step();
      cmp("pend_fourth_jv", 32'(judge_valid), 0);

      // T5 score saturation
      restart();
      repeat (100) hit(0, 0);
      step(); step();
      settle();
      cmp("t5_score", 32'(score), 65535);
      cmp("t5_combo", 32'(combo), 100);

      // combo saturation
      restart();
      repeat (1030) hit(1, 0);
      cmp("combo_sat", 32'(combo), 1023);

      // T6 events ignored after song_end
      song_end = 1'b1; step(); song_end = 1'b0;
      cmp("t6_playing", 32'(playing), 0);
      hit(0, 0);
      cmp("t6_jv", 32'(judge_valid), 0);
      cmp("t6_combo_held", 32'(combo), 1023);

      // reset mid-song
      restart();
      hit(3, 0);
      reset = 1'b1; step(); reset = 1'b0;
      cmp("t6_rst_score", 32'(score), 0);
      cmp("t6_rst_combo", 32'(combo), 0);
      cmp("t6_rst_judge", 32'(judgement), 0);
      cmp("t6_rst_jv", 32'(judge_valid), 0);
      cmp("t6_rst_playing", 32'(playing), 0);

      // frame-by-frame display of a 300 raw score
      restart();
      hit(3, 0);
      step(); step();
      for (int k = 1; k <= 5; k++) begin
         frame();
`ifdef SCORE_ROLLUP_EN
         exp_s = (64 * k < 300) ? 64 * k : 300;
`else
         exp_s = 300;
`endif
         cmp("t6_frame", 32'(score), 32'(exp_s));
      end

      // random phase
      restart();
      for (int i = 0; i < 5000; i++) begin
         reset      = ($urandom_range(499) == 0);
         song_start = ($urandom_range(99) < 2);
         song_end   = ($urandom_range(199) == 0);
         hit_valid  = ($urandom_range(99) < 45);
         miss_valid = ($urandom_range(99) < 20);
         hit_dist   = ($urandom_range(9) == 0)
                    ? 10'($urandom_range(1023))
                    : 10'($urandom_range(30));
         if ($urandom_range(3) == 0) frame_clk = ~frame_clk;
         step();
      end
      reset = 1'b0; song_start = 1'b0; song_end = 1'b0;
      hit_valid = 1'b0; miss_valid = 1'b0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
